// File: rtl/uart_stim_pkg.sv
// Shared types and frame constants for the bench-side UART stimulus transmitter.
package uart_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_stim_tx_if.sv
// Write/status bundle of uart_stim_tx; master is the stimulus source, slave is the transmitter.
interface uart_stim_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          WR_EN;
    logic [7:0]    WR_DATA;
    logic          FULL;
    logic          EMPTY;
    logic [LW-1:0] LEVEL;
    logic          BUSY;
    logic          OVERRUN;
    logic          UART_TXD;

    modport master (
        output WR_EN, WR_DATA,
        input  FULL, EMPTY, LEVEL, BUSY, OVERRUN, UART_TXD
    );

    modport slave (
        input  WR_EN, WR_DATA,
        output FULL, EMPTY, LEVEL, BUSY, OVERRUN, UART_TXD
    );

endinterface

// File: rtl/uart_stim_fifo.sv
// Single-clock byte FIFO with occupancy and sticky overrun flag; async active-high reset XRES.
module uart_stim_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     XCLK,
    input  logic                     XRES,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // The extra pointer MSB distinguishes full from empty when the index bits match.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge XCLK) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
            if (push && full) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_stim_tx.sv
// Bench-side UART transmitter: byte FIFO feeding an 8N1 serialiser, LSB first.
// Define UART_STIM_PARITY_EN to insert an even-parity bit (8E1).
`ifndef BOARD_CK
`define BOARD_CK 100000000
`endif

module uart_stim_tx
    import uart_stim_pkg::*;
#(
    parameter int CLK_HZ     = `BOARD_CK,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV        = calc_div(CLK_HZ, BAUD)
) (
    input  logic          XCLK,
    input  logic          XRES,
    uart_stim_tx_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] RELOAD   = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    state_t                 state;
    logic [CW-1:0]          baud_cnt;
    logic [IW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   txd;
    logic                   pop;
    logic                   fifo_empty;
    logic [7:0]             head;
`ifdef UART_STIM_PARITY_EN
    logic                   parity;
`endif

    uart_stim_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .XCLK      (XCLK),
        .XRES      (XRES),
        .push      (bus.WR_EN),
        .push_data (bus.WR_DATA),
        .pop       (pop),
        .head      (head),
        .full      (bus.FULL),
        .empty     (fifo_empty),
        .level     (bus.LEVEL),
        .overrun   (bus.OVERRUN)
    );

    assign pop          = (state == ST_IDLE) && !fifo_empty;
    assign bus.EMPTY    = fifo_empty;
    assign bus.BUSY     = (state != ST_IDLE);
    assign bus.UART_TXD = txd;

    // txd is registered one edge ahead, so each state sees its own bit already on the line.
    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= STOP_LEVEL;
`ifdef UART_STIM_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift    <= head;
                        baud_cnt <= RELOAD;
                        txd      <= START_LEVEL;
                        state    <= ST_START;
`ifdef UART_STIM_PARITY_EN
                        parity   <= ^head;
`endif
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= RELOAD;
                        bit_idx  <= '0;
                        txd      <= shift[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= RELOAD;
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_STIM_PARITY_EN
                            txd   <= parity;
                            state <= ST_PARITY;
`else
                            txd   <= STOP_LEVEL;
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
`ifdef UART_STIM_PARITY_EN
                ST_PARITY: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= RELOAD;
                        txd      <= STOP_LEVEL;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    txd   <= STOP_LEVEL;
                end
            endcase
        end
    end

endmodule
